rv_decode: RTL

- Instruction decode stage for RV32I.
- Accepts a fetched instruction and its PC over a valid/ready handshake.
- Generates the 5-bit ALU control word, the operand selects, the immediate and the register/memory control fields that the execute stage and its ALU consume.
- Output is registered behind a 2-entry skid buffer, so o_ready depends on no downstream combinational path.

---
 rtl/rv_decode.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rv_decode.sv
// rv_decode: RV32I decode stage; decoded bundle is registered behind a 2-entry skid buffer.
// Ports:
//   i_clk, i_reset (async, active high), i_flush (drop buffered and incoming instructions)
//   fetch side   : i_valid, o_ready, i_instr, i_pc
//   execute side : o_valid, i_ready, o_pc, o_alu_ctrl, o_src_a_sel, o_src_b_sel, o_imm,
//                  o_rs1, o_rs2, o_rd, o_funct3, o_res_src,
//                  o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump, o_illegal
module rv_decode #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_alu_ctrl,
  output logic [1:0]      o_src_a_sel,
  output logic            o_src_b_sel,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [2:0]      o_funct3,
  output logic [1:0]      o_res_src,
  output logic            o_reg_write,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_illegal
);
  localparam logic [4:0] ALU_ADD = 5'b01000, ALU_SUB = 5'b01001, ALU_XOR = 5'b01010,
                         ALU_SHL = 5'b01011, ALU_OR  = 5'b01100, ALU_SHR = 5'b01101,
                         ALU_AND = 5'b01110, ALU_SRA = 5'b11101, ALU_LTS = 5'b00010,
                         ALU_LTU = 5'b00100;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
  // pc must stay the first (most significant) field: the reset value relies on it
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      alu;
    logic [1:0]      a_sel;
    logic            b_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic [1:0]      res;
    logic            rw;
    logic            mr;
    logic            mw;
    logic            br;
    logic            jp;
    logic            ill;
  } bundle_t;
  typedef enum logic [1:0] {EMPTY, MAIN, SKID} state_t;
  localparam bundle_t RST_B = bundle_t'({RESET_PC, {($bits(bundle_t) - XLEN){1'b0}}});
  state_t state, state_n;
  bundle_t dec, main_q, skid_q;
  logic ready_q, accept, drain, load_main, from_skid, load_skid;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd, alu;
  logic [1:0] a_sel, res;
  logic b_sel, rw, mr, mw, br, jp, ill;
  logic [XLEN-1:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j;
  function automatic logic [4:0] arith(input logic [2:0] f, input logic alt);
    case (f)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SHL;
      3'b010:  return ALU_LTS;
      3'b011:  return ALU_LTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SHR;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  assign op = i_instr[6:0];
  assign rd = i_instr[11:7];
  assign f3 = i_instr[14:12];
  assign f7 = i_instr[31:25];
  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'b0};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  always_comb begin
    alu = '0;
    a_sel = 2'd0;
    b_sel = 1'b0;
    imm = '0;
    res = 2'd0;
    rw = 1'b0;
    mr = 1'b0;
    mw = 1'b0;
    br = 1'b0;
    jp = 1'b0;
    ill = 1'b0;
    case (op)
      OP_LUI:   begin alu = ALU_ADD; a_sel = 2'd2; b_sel = 1'b1; imm = imm_u; rw = 1'b1; end
      OP_AUIPC: begin alu = ALU_ADD; a_sel = 2'd1; b_sel = 1'b1; imm = imm_u; rw = 1'b1; end
      OP_JAL:   begin alu = ALU_ADD; a_sel = 2'd1; b_sel = 1'b1; imm = imm_j; jp = 1'b1; res = 2'd2; rw = 1'b1; end
      OP_JALR:  begin alu = ALU_ADD; b_sel = 1'b1; imm = imm_i; jp = 1'b1; res = 2'd2; rw = 1'b1; end
      OP_BRANCH: begin
        // 00x -> EQ/NEQ (0/1), 1xx -> LTS..NLTU (2..5); 01x has no compare
        alu = f3[2] ? 5'(f3[1:0]) + 5'd2 : {4'b0, f3[0]};
        imm = imm_b;
        br = 1'b1;
        ill = f3[2:1] == 2'b01;
      end
      OP_LOAD:  begin alu = ALU_ADD; b_sel = 1'b1; imm = imm_i; mr = 1'b1; res = 2'd1; rw = 1'b1; end
      OP_STORE: begin alu = ALU_ADD; b_sel = 1'b1; imm = imm_s; mw = 1'b1; end
      OP_IMM: begin
        // instr[30] only selects SRA for right shifts; for addi it is immediate data
        alu = arith(f3, f3 == 3'b101 && f7[5]);
        b_sel = 1'b1;
        imm = imm_i;
        rw = 1'b1;
        ill = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_REG: begin
        alu = arith(f3, f7[5]);
        rw = 1'b1;
        ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      default: ill = 1'b1;
    endcase
  end
  assign dec = '{pc: i_pc, alu: alu, a_sel: a_sel, b_sel: b_sel, imm: imm,
                 rs1: i_instr[19:15], rs2: i_instr[24:20], rd: rd, f3: f3, res: res,
                 rw: rw && !ill && rd != 5'd0, mr: mr && !ill, mw: mw && !ill,
                 br: br && !ill, jp: jp && !ill, ill: ill};
  assign o_valid = state != EMPTY;
  assign o_ready = ready_q;
  assign accept = i_valid && o_ready;
  assign drain = o_valid && i_ready;
  always_comb begin
    state_n = state;
    load_main = 1'b0;
    from_skid = 1'b0;
    load_skid = 1'b0;
    case (state)
      EMPTY: if (accept) begin state_n = MAIN; load_main = 1'b1; end
      MAIN: begin
        state_n = accept ? (drain ? MAIN : SKID) : (drain ? EMPTY : MAIN);
        load_main = accept && drain;
        load_skid = accept && !drain;
      end
      SKID: if (drain) begin state_n = MAIN; from_skid = 1'b1; end
      default: state_n = EMPTY;
    endcase
    if (i_flush) begin
      state_n = EMPTY;
      load_main = 1'b0;
      from_skid = 1'b0;
      load_skid = 1'b0;
    end
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= EMPTY;
      ready_q <= 1'b1;
      main_q <= RST_B;
      skid_q <= '0;
    end else begin
      state <= state_n;
      ready_q <= state_n != SKID;
      if (load_main) main_q <= dec;
      else if (from_skid) main_q <= skid_q;
      if (load_skid) skid_q <= dec;
    end
  assign o_pc = main_q.pc;
  assign o_alu_ctrl = main_q.alu;
  assign o_src_a_sel = main_q.a_sel;
  assign o_src_b_sel = main_q.b_sel;
  assign o_imm = main_q.imm;
  assign o_rs1 = main_q.rs1;
  assign o_rs2 = main_q.rs2;
  assign o_rd = main_q.rd;
  assign o_funct3 = main_q.f3;
  assign o_res_src = main_q.res;
  assign o_reg_write = main_q.rw;
  assign o_mem_read = main_q.mr;
  assign o_mem_write = main_q.mw;
  assign o_branch = main_q.br;
  assign o_jump = main_q.jp;
  assign o_illegal = main_q.ill;
endmodule
